// File: rtl/spi_mux_adapter.sv
// SPI push/pull adapter for num_ch val/rdy channels: writes are steered to per-channel mc queues,
// cm queues are round-robin merged onto pull_msg. Define SPI_MUX_ADAPTER_DROP_CNT_EN for drop_cnt.
module spi_mux_adapter #(
   parameter int unsigned nbits       = 8,
   parameter int unsigned num_entries = 2,
   parameter int unsigned num_ch      = 4,
   localparam int unsigned CW = $clog2(num_ch),
   localparam int unsigned NQ = 2 * num_ch,
   localparam int unsigned PW = (num_entries > 1) ? $clog2(num_entries) : 1,
   localparam int unsigned NW = $clog2(num_entries + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_en,
   input  logic [2+CW+nbits-1:0]        push_msg,
   input  logic                         pull_en,
   output logic [1+num_ch+CW+nbits-1:0] pull_msg,
   input  logic [num_ch*nbits-1:0]      recv_msg,
   input  logic [num_ch-1:0]            recv_val,
   output logic [num_ch-1:0]            recv_rdy,
   output logic [num_ch*nbits-1:0]      send_msg,
   output logic [num_ch-1:0]            send_val,
   input  logic [num_ch-1:0]            send_rdy
`ifdef SPI_MUX_ADAPTER_DROP_CNT_EN
   ,
   output logic [7:0]                   drop_cnt
`endif
);

   // Queues 0..num_ch-1 are mc (SPI -> endpoint), num_ch..NQ-1 are cm (endpoint -> SPI).
   logic [nbits-1:0] mem    [NQ][num_entries];
   logic [PW-1:0]    head_q [NQ];
   logic [PW-1:0]    tail_q [NQ];
   logic [NW-1:0]    cnt_q  [NQ];
   logic [nbits-1:0] din    [NQ];
   logic [nbits-1:0] cm_head[num_ch];
   logic [NQ-1:0]    q_val, q_rdy, enq, deq;
   logic [num_ch-1:0] wr, spc, cm_val;
   logic [CW-1:0]    rr_q, rr_d, grant, idx;
   logic             found, rd, pull_val;

   logic             val_wrt, val_rd;
   logic [CW-1:0]    push_ch;
   logic [nbits-1:0] push_data;

   assign val_wrt   = push_msg[1+CW+nbits];
   assign val_rd    = push_msg[CW+nbits];
   assign push_ch   = push_msg[nbits +: CW];
   assign push_data = push_msg[nbits-1:0];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(num_entries - 1)) return '0;
      return p + PW'(1);
   endfunction

   always_comb begin
      q_val = '0;
      q_rdy = '0;
      for (int i = 0; i < NQ; i++) begin
         q_val[i] = (cnt_q[i] != '0);
         q_rdy[i] = (cnt_q[i] < NW'(num_entries));
      end
   end

   assign cm_val = q_val[NQ-1:num_ch];

   // Round-robin scan starting at rr_q; first non-empty cm queue wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < num_ch; k++) begin
         idx = CW'((int'(rr_q) + k) % int'(num_ch));
         if (!found && cm_val[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign rd       = pull_en & val_rd;
   assign pull_val = rd & (|cm_val);

   always_comb begin
      wr       = '0;
      spc      = '0;
      enq      = '0;
      deq      = '0;
      send_val = '0;
      send_msg = '0;
      recv_rdy = '0;
      for (int i = 0; i < NQ; i++) din[i] = '0;
      for (int i = 0; i < num_ch; i++) begin
         wr[i]  = push_en & val_wrt & (push_ch == CW'(i));
         // A same-cycle mc dequeue is deliberately not credited.
         spc[i] = ({1'b0, cnt_q[i]} + (NW+1)'(wr[i])) < (NW+1)'(num_entries);
         enq[i] = wr[i] & q_rdy[i];
         din[i] = push_data;
         deq[i] = q_val[i] & send_rdy[i];
         send_val[i] = q_val[i];
         send_msg[i*nbits +: nbits] = mem[i][head_q[i]];
         enq[num_ch+i] = recv_val[i] & q_rdy[num_ch+i];
         din[num_ch+i] = recv_msg[i*nbits +: nbits];
         deq[num_ch+i] = pull_val & (grant == CW'(i));
         recv_rdy[i]   = q_rdy[num_ch+i];
         cm_head[i]    = mem[num_ch+i][head_q[num_ch+i]];
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (pull_val) rr_d = (grant == CW'(num_ch - 1)) ? '0 : grant + CW'(1);
   end

   assign pull_msg = {pull_val, spc, pull_val ? grant : CW'(0),
                      pull_val ? cm_head[grant] : nbits'(0)};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NQ; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         rr_q <= '0;
      end else begin
         for (int i = 0; i < NQ; i++) begin
            if (enq[i]) tail_q[i] <= ptr_inc(tail_q[i]);
            if (deq[i]) head_q[i] <= ptr_inc(head_q[i]);
            if (enq[i] && !deq[i])      cnt_q[i] <= cnt_q[i] + NW'(1);
            else if (!enq[i] && deq[i]) cnt_q[i] <= cnt_q[i] - NW'(1);
         end
         rr_q <= rr_d;
      end
   end

   // Data storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NQ; i++) begin
         if (enq[i]) mem[i][tail_q[i]] <= din[i];
      end
   end

`ifdef SPI_MUX_ADAPTER_DROP_CNT_EN
   logic       drop;
   logic [7:0] drop_q;

   // Any write that no queue accepts: full target or out-of-range channel.
   assign drop = push_en & val_wrt & ~(|(wr & q_rdy[num_ch-1:0]));

   always_ff @(posedge clk) begin
      if (reset) drop_q <= '0;
      else if (drop && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
   end

   assign drop_cnt = drop_q;
`endif

endmodule
